// File: rtl/button_event_pkg.sv
// Shared button definitions: FSM state encoding, default timing constants
// used by every button consumer, and the counter-width helper.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

    // Counter width large enough to reach the larger of the two thresholds.
    function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                              input int unsigned repeat_cycles);
        int unsigned m;
        int unsigned w;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_event_if.sv
// Button event bundle: debounced level in, one-cycle events and held level out.
// Handshake: none; pressed is a level sampled every rising edge, and each
// *_pulse is a single-cycle strobe with no ready/back-pressure.
// state is a debug view of the event FSM.
interface button_event_if;
    import button_event_pkg::*;

    logic   pressed;
    logic   press_pulse;
    logic   release_pulse;
    logic   long_pulse;
    logic   repeat_pulse;
    logic   held;
    state_t state;

    // Source of the button level, consumer of the events.
    modport master (
        output pressed,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, state
    );

    // The event generator itself.
    modport slave (
        input  pressed,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, state
    );

endinterface

// File: rtl/button_event_event_timer.sv
// Hold-time counter: synchronous clear, increment enable, and a compare
// against a caller-supplied terminal value. Saturates instead of wrapping.
module event_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt;

    // Count register: cleared by reset or clear, otherwise counts when enabled.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press, release, long-press and
// auto-repeat one-cycle events. All event outputs are registered.
module button_event
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    button_event_if.slave bus
);

    localparam int unsigned         CNT_W    = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0]    LONG_LIM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]    REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q;
    state_t           state_n;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_limit;

    logic press_n, release_n, long_n, repeat_n;
    logic press_q, release_q, long_q, repeat_q;

    // The single timer serves both phases; its terminal value follows the state.
    assign cnt_limit = (state_q == REPEAT) ? REP_LIM : LONG_LIM;

    event_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .hit   (cnt_hit)
    );

    // Next-state and next-pulse decode; release is checked before any threshold.
    always_comb begin
        state_n   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (bus.pressed) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                end
            end
            PRESSED: begin
                if (!bus.pressed) begin
                    state_n   = IDLE;
                    cnt_clear = 1'b1;
                    release_n = 1'b1;
                end else if (cnt_hit) begin
                    state_n   = REPEAT;
                    cnt_clear = 1'b1;
                    long_n    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            REPEAT: begin
                if (!bus.pressed) begin
                    state_n   = IDLE;
                    cnt_clear = 1'b1;
                    release_n = 1'b1;
                end else if (cnt_hit) begin
                    cnt_clear = 1'b1;
                    repeat_n  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // State and event registers; reset drops an in-flight press silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            press_q   <= press_n;
            release_q <= release_n;
            long_q    <= long_n;
            repeat_q  <= repeat_n;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = (state_q != IDLE);
    assign bus.state         = state_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (repeat period 3 and 1) share one
// stimulus stream; expected events come from the length of the current hold.
module tb_button_event;
    import button_event_pkg::*;

    localparam int L  = 8;
    localparam int RA = 3;
    localparam int RB = 1;

    logic clk = 1'b0;
    logic reset;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: number of consecutive high samples in the current press.
    int   hold = 0;
    logic e_press, e_rel, e_long, e_rep_a, e_rep_b, e_held;

    button_event_if bus_a ();
    button_event_if bus_b ();

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(RA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(RB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs for the cycle after an edge, from the hold length.
    task automatic model(input logic p, input logic r);
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        e_rep_a = 1'b0; e_rep_b = 1'b0; e_held = 1'b0;
        if (!r) begin
            hold = 0;
        end else if (p) begin
            hold++;
            e_held  = 1'b1;
            e_press = (hold == 1);
            e_long  = (hold == L + 1);
            e_rep_a = (hold > L + 1) && (((hold - L - 1) % RA) == 0);
            e_rep_b = (hold > L + 1) && (((hold - L - 1) % RB) == 0);
        end else begin
            e_rel = (hold > 0);
            hold  = 0;
        end
    endtask

    task automatic check_all();
        chk("a_press",   bus_a.press_pulse,   e_press);
        chk("a_release", bus_a.release_pulse, e_rel);
        chk("a_long",    bus_a.long_pulse,    e_long);
        chk("a_repeat",  bus_a.repeat_pulse,  e_rep_a);
        chk("a_held",    bus_a.held,          e_held);
        chk("a_state_busy", bus_a.state != IDLE, e_held);
        chk("b_press",   bus_b.press_pulse,   e_press);
        chk("b_release", bus_b.release_pulse, e_rel);
        chk("b_long",    bus_b.long_pulse,    e_long);
        chk("b_repeat",  bus_b.repeat_pulse,  e_rep_b);
        chk("b_held",    bus_b.held,          e_held);
        chk("a_onehot",
            ($countones({bus_a.press_pulse, bus_a.release_pulse,
                         bus_a.long_pulse, bus_a.repeat_pulse}) <= 1), 1'b1);
    endtask

    // Driver: apply inputs mid-cycle, advance one edge, check just after it.
    task automatic step(input logic p, input logic r);
        @(negedge clk);
        reset         = r;
        bus_a.pressed = p;
        bus_b.pressed = p;
        @(posedge clk);
        cyc++;
        model(p, r);
        #1;
        check_all();
    endtask

    task automatic hold_level(input logic p, input int n);
        for (int i = 0; i < n; i++) step(p, 1'b1);
    endtask

    initial begin
        int   run;
        logic lvl;
        reset         = 1'b0;
        bus_a.pressed = 1'b0;
        bus_b.pressed = 1'b0;

        // Reset held low with pressed toggling: everything stays quiet.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        hold_level(1'b0, 2);

        // Short press.
        hold_level(1'b1, 4);
        hold_level(1'b0, 3);

        // Long press with repeats.
        hold_level(1'b1, 20);
        hold_level(1'b0, 3);

        // Release on the same edge the long threshold would hit.
        hold_level(1'b1, 8);
        hold_level(1'b0, 3);

        // Reset in REPEAT with the button still down, then resume.
        hold_level(1'b1, 10);
        step(1'b1, 1'b0);
        hold_level(1'b1, 4);
        hold_level(1'b0, 2);

        // Single-sample glitch.
        step(1'b1, 1'b1);
        hold_level(1'b0, 2);

        // Random hold lengths with occasional resets.
        lvl = 1'b0;
        for (int k = 0; k < 80; k++) begin
            lvl = ~lvl;
            run = $urandom_range(1, 25);
            for (int i = 0; i < run; i++) begin
                if ($urandom_range(0, 59) == 0) step(lvl, 1'b0);
                else                            step(lvl, 1'b1);
            end
        end
        hold_level(1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
